// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: interrupt source indices, vector base and
// the interrupt-controller state type.
package gb_pkg;

  localparam int unsigned INT_VBLANK = 0;
  localparam int unsigned INT_LCDC   = 1;
  localparam int unsigned INT_TIMER  = 2;
  localparam int unsigned INT_SERIAL = 3;
  localparam int unsigned INT_JOYPAD = 4;
  localparam int unsigned INT_NUM    = 5;

  localparam logic [7:0] INT_VEC_BASE = 8'h40;

  typedef enum logic [0:0] {
    INT_IDLE = 1'b0,
    INT_ACK  = 1'b1
  } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt sources.
module int_prio_enc
  import gb_pkg::*;
(
  input  logic [INT_NUM-1:0] req,
  output logic [2:0]         sel,
  output logic               any
);

  always_comb begin
    sel = 3'd0;
    any = |req;
    // Walk downward so the lowest set index is the last one written.
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, CPU request line and
// restart-vector supply during the acknowledge cycle.
module int_ctrl
  import gb_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = INT_VEC_BASE,
  parameter bit         EDGE_DET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       irq_vblank,
  input  logic       irq_lcdc,
  input  logic       irq_timer,
  input  logic       irq_serial,
  input  logic       irq_joypad,
  input  logic       cpu_sel_if,
  input  logic       cpu_sel_ie,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       cpu_irq_n,
  input  logic       cpu_int_ack,
  output logic [7:0] cpu_vector
);

  logic [INT_NUM-1:0] src, src_prev, src_new;
  logic [INT_NUM-1:0] if_r, if_d, if_base, ack_clr, pend;
  logic [7:0]         ie_r, vec_r, vec_d;
  logic [2:0]         sel;
  logic               any;
  int_state_e         state, state_d;

  assign src     = {irq_joypad, irq_serial, irq_timer, irq_lcdc, irq_vblank};
  assign src_new = EDGE_DET ? (src & ~src_prev) : src;
  assign pend    = if_r & ie_r[INT_NUM-1:0];

  int_prio_enc u_prio (
    .req (pend),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    state_d = state;
    vec_d   = vec_r;
    ack_clr = '0;
    case (state)
      INT_IDLE: begin
        if (cpu_int_ack) begin
          state_d = INT_ACK;
          // No pending source left at ack time: hand out 00 (cancelled interrupt).
          vec_d   = any ? (VEC_BASE + {2'b00, sel, 3'b000}) : 8'h00;
          if (any) ack_clr = {{(INT_NUM-1){1'b0}}, 1'b1} << sel;
        end
      end
      INT_ACK: begin
        if (!cpu_int_ack) state_d = INT_IDLE;
      end
      default: state_d = INT_IDLE;
    endcase
  end

  // Write lands first, then the ack clear; new source events override both.
  always_comb begin
    if_base = (cpu_sel_if && cpu_wr) ? cpu_di[INT_NUM-1:0] : if_r;
    if_base = if_base & ~ack_clr;
    if_d    = if_base | src_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_r     <= '0;
      ie_r     <= 8'h00;
      src_prev <= '0;
      state    <= INT_IDLE;
      vec_r    <= 8'h00;
    end else begin
      if_r     <= if_d;
      src_prev <= src;
      state    <= state_d;
      vec_r    <= vec_d;
      if (cpu_sel_ie && cpu_wr) ie_r <= cpu_di;
    end
  end

  assign cpu_irq_n  = (state == INT_ACK) ? 1'b1 : ~|pend;
  assign cpu_vector = vec_r;

  always_comb begin
    if (cpu_sel_if)      cpu_do = {3'b111, if_r};
    else if (cpu_sel_ie) cpu_do = ie_r;
    else                 cpu_do = 8'hFF;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed and randomized bench for int_ctrl against a behavioural model.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] srcv;
  logic       cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_int_ack;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do, cpu_vector;
  logic       cpu_irq_n;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [4:0] m_prev;
  logic       m_ack;
  logic [7:0] m_vec;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_vblank  (srcv[0]),
    .irq_lcdc    (srcv[1]),
    .irq_timer   (srcv[2]),
    .irq_serial  (srcv[3]),
    .irq_joypad  (srcv[4]),
    .cpu_sel_if  (cpu_sel_if),
    .cpu_sel_ie  (cpu_sel_ie),
    .cpu_wr      (cpu_wr),
    .cpu_di      (cpu_di),
    .cpu_do      (cpu_do),
    .cpu_irq_n   (cpu_irq_n),
    .cpu_int_ack (cpu_int_ack),
    .cpu_vector  (cpu_vector)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_prev = '0; m_ack = 1'b0; m_vec = 8'h00;
  endtask

  // Applies one clock edge of the interrupt rules to the model.
  task automatic model_edge();
    logic [4:0] nw, base;
    int p;
    nw     = srcv & ~m_prev;
    m_prev = srcv;
    base   = (cpu_sel_if && cpu_wr) ? cpu_di[4:0] : m_if;
    if (!m_ack && cpu_int_ack) begin
      p = -1;
      for (int n = 0; n < 5; n++) if (p < 0 && m_if[n] && m_ie[n]) p = n;
      if (p >= 0) begin
        m_vec = 8'h40 + 8'(p * 8);
        base  = base & ~(5'b00001 << p);
      end else begin
        m_vec = 8'h00;
      end
      m_ack = 1'b1;
    end else if (m_ack && !cpu_int_ack) begin
      m_ack = 1'b0;
    end
    if (cpu_sel_ie && cpu_wr) m_ie = cpu_di;
    m_if = base | nw;
  endtask

  task automatic check_outs();
    logic       e_irq;
    logic [7:0] e_do;
    e_irq = m_ack ? 1'b1 : ~|(m_if & m_ie[4:0]);
    if (cpu_sel_if)      e_do = {3'b111, m_if};
    else if (cpu_sel_ie) e_do = m_ie;
    else                 e_do = 8'hFF;
    chk("model_irq_n", {7'b0, cpu_irq_n}, {7'b0, e_irq});
    chk("model_vector", cpu_vector, m_vec);
    chk("model_do", cpu_do, e_do);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic rd(input string tag, input bit sel_if, input logic [7:0] exp);
    cpu_sel_if = sel_if;
    cpu_sel_ie = ~sel_if;
    #1;
    chk(tag, cpu_do, exp);
    cpu_sel_if = 1'b0;
    cpu_sel_ie = 1'b0;
  endtask

  task automatic wr_reg(input bit sel_if, input logic [7:0] d);
    cpu_sel_if = sel_if;
    cpu_sel_ie = ~sel_if;
    cpu_wr     = 1'b1;
    cpu_di     = d;
    cyc();
    cpu_sel_if = 1'b0;
    cpu_sel_ie = 1'b0;
    cpu_wr     = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_vec [3];
    exp_vec = '{8'h40, 8'h58, 8'h60};
    reset_n = 1'b0; srcv = '0; cpu_sel_if = 0; cpu_sel_ie = 0; cpu_wr = 0;
    cpu_int_ack = 0; cpu_di = 8'h00;
    model_reset();
    #12 reset_n = 1'b1;

    // Reset state
    rd("reset_if", 1'b1, 8'hE0);
    rd("reset_ie", 1'b0, 8'h00);
    chk("reset_irq_n", {7'b0, cpu_irq_n}, 8'h01);
    chk("reset_vector", cpu_vector, 8'h00);

    // Timer interrupt end to end
    wr_reg(1'b0, 8'h04);
    srcv[2] = 1'b1; cyc(); srcv = '0;
    rd("timer_if_set", 1'b1, 8'hE4);
    chk("timer_irq_low", {7'b0, cpu_irq_n}, 8'h00);
    cpu_int_ack = 1'b1; cyc();
    chk("timer_vector", cpu_vector, 8'h50);
    rd("timer_if_clr", 1'b1, 8'hE0);
    chk("ack_irq_held", {7'b0, cpu_irq_n}, 8'h01);
    cyc();
    chk("ack_irq_held2", {7'b0, cpu_irq_n}, 8'h01);
    cpu_int_ack = 1'b0; cyc(); cyc();

    // Three simultaneous sources served in priority order
    wr_reg(1'b0, 8'h1F);
    srcv = 5'b11001; cyc(); srcv = '0;
    for (int k = 0; k < 3; k++) begin
      cpu_int_ack = 1'b1; cyc();
      chk("prio_vector", cpu_vector, exp_vec[k]);
      cpu_int_ack = 1'b0; cyc();
    end
    rd("prio_if_end", 1'b1, 8'hE0);

    // Source beats a same-cycle IF write
    wr_reg(1'b0, 8'h04);
    cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = 8'h00; srcv[2] = 1'b1;
    cyc();
    cpu_sel_if = 1'b0; cpu_wr = 1'b0; srcv = '0;
    rd("src_wins", 1'b1, 8'hE4);
    wr_reg(1'b1, 8'h00);

    // Enable gating
    wr_reg(1'b0, 8'h00);
    wr_reg(1'b1, 8'h01);
    cyc();
    chk("gated_irq_n", {7'b0, cpu_irq_n}, 8'h01);
    wr_reg(1'b0, 8'h01);
    chk("enabled_irq_n", {7'b0, cpu_irq_n}, 8'h00);
    wr_reg(1'b1, 8'hE0);
    rd("if_upper_ro", 1'b1, 8'hE0);
    wr_reg(1'b0, 8'h00);

    // Cancelled acknowledge
    cpu_int_ack = 1'b1; cyc();
    chk("cancel_vector", cpu_vector, 8'h00);
    rd("cancel_if", 1'b1, 8'hE0);
    cpu_int_ack = 1'b0; cyc();

    // Held level only registers one edge
    srcv[2] = 1'b1;
    repeat (3) cyc();
    rd("level_if_set", 1'b1, 8'hE4);
    wr_reg(1'b1, 8'h00);
    repeat (6) cyc();
    rd("level_once", 1'b1, 8'hE0);
    srcv = '0; cyc();

    // Reset in the middle of an acknowledge
    wr_reg(1'b0, 8'h04);
    srcv[2] = 1'b1; cyc(); srcv = '0;
    cpu_int_ack = 1'b1; cyc();
    chk("pre_rst_vector", cpu_vector, 8'h50);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_irq_n", {7'b0, cpu_irq_n}, 8'h01);
    chk("rst_vector", cpu_vector, 8'h00);
    model_reset();
    cpu_int_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 5; b++) srcv[b] = ($urandom_range(0, 3) == 0);
      cpu_sel_if = ($urandom_range(0, 3) == 0);
      cpu_sel_ie = ($urandom_range(0, 3) == 0);
      cpu_wr     = ($urandom_range(0, 2) == 0);
      cpu_di     = 8'($urandom);
      if ($urandom_range(0, 3) == 0) cpu_int_ack = ~cpu_int_ack;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Game Boy interrupt controller that sits directly downstream of the timer, video, serial and joypad blocks.
- Turns their one-cycle request pulses into the IF (FF0F) and IE (FFFF) registers.
- Drives the CPU interrupt request line.
- On the CPU's interrupt acknowledge, supplies the restart vector of the highest-priority pending, enabled source and clears that IF bit.

Parameters:
VEC_BASE, 8'h40, vector of source 0 (vblank); source n vector = VEC_BASE + 8*n
EDGE_DET, 1, 1 = set IF on rising edge of source input; 0 = set IF on every cycle the input is high

Ports:
clk  in  1  4 MHz CPU clock
reset_n  in  1  asynchronous active-low reset
irq_vblank  in  1  source 0 request
irq_lcdc  in  1  source 1 request
irq_timer  in  1  source 2 request (timer irq pulse)
irq_serial  in  1  source 3 request
irq_joypad  in  1  source 4 request
cpu_sel_if  in  1  CPU access selects IF (FF0F)
cpu_sel_ie  in  1  CPU access selects IE (FFFF)
cpu_wr  in  1  write strobe, qualified by a select
cpu_di  in  8  write data
cpu_do  out  8  read data
cpu_irq_n  out  1  active-low interrupt request to CPU
cpu_int_ack  in  1  high while CPU runs its interrupt-acknowledge cycle
cpu_vector  out  8  restart vector, valid from cycle after ack rise until ack falls

Behaviour:
- Reset (async, reset_n low) clears:
  - if_r[4:0]=0, ie_r[7:0]=0
  - src_prev=0, state=IDLE, vec_r=8'h00
  - resulting outputs: cpu_irq_n=1, cpu_vector=8'h00
- Source capture:
  - EDGE_DET=1: new[n] = src[n] & ~src_prev[n]; src_prev registered every cycle.
  - EDGE_DET=0: new[n] = src[n].
- IF next value, in this order:
  - base = IF write ? cpu_di[4:0] : if_r
  - base &= ~ack_clr
  - if_r <= base | new
  - A new source event always wins over a CPU write or an ack clear on the same bit in the same cycle.
- IE: written only when cpu_sel_ie & cpu_wr; all 8 bits stored; only [4:0] gate interrupts.
- pend = if_r & ie_r[4:0]; sel = lowest set index of pend (0 highest priority).
- Read path, combinational:
  - cpu_sel_if → {3'b111, if_r}
  - cpu_sel_ie → ie_r
  - otherwise 8'hFF
- Latency: a source pulse in cycle N sets if_r at the end of N; cpu_irq_n goes low in N+1 if the source is enabled.
- State machine, states IDLE and ACK:
  - IDLE:
    - cpu_irq_n = ~|pend.
    - On cpu_int_ack=1:
      - vec_r <= pend ? VEC_BASE + 8*sel : 8'h00 (cancelled-interrupt case).
      - ack_clr = onehot(sel) when pend != 0, else 0.
      - Go to ACK.
  - ACK:
    - cpu_irq_n = 1 regardless of pend, so the same acknowledge is never re-entered.
    - cpu_vector = vec_r; if_r clears and source sets proceed normally.
    - On cpu_int_ack=0, go to IDLE. cpu_irq_n then re-evaluates in that same cycle.
- cpu_vector = vec_r at all times; it holds its value after ACK until the next acknowledge.
- Ack rising with a simultaneous IF write: the write lands first, then the ack clear, so the priority choice is made on the pre-write if_r.
- Writing IF with bits [7:5] set: the bits are ignored and always read back as 1.
- Async reset during ACK returns to IDLE immediately; vector cleared.

Decomposition:
- Shared package gb_pkg holds:
  - source index constants INT_VBLANK=0, INT_LCDC=1, INT_TIMER=2, INT_SERIAL=3, INT_JOYPAD=4, INT_NUM=5
  - INT_VEC_BASE=8'h40
  - a state enum {INT_IDLE, INT_ACK}
- One sub-module, int_prio_enc: combinational 5-bit lowest-index priority encoder giving sel[2:0] and any.
- Everything else stays in int_ctrl.

Test Plan:
- Reset, then read FF0F and FFFF → 8'hE0 and 8'h00; cpu_irq_n=1.
- Write IE=8'h04; pulse irq_timer for 1 cycle → IF reads 8'hE4; cpu_irq_n=0 one cycle after the pulse; raise cpu_int_ack → cpu_vector=8'h50, IF=8'hE0, cpu_irq_n held 1 until ack drops.
- IE=8'h1F; pulse vblank, serial and joypad in the same cycle; ack three times → vectors 8'h40, 8'h58, 8'h60 in order; IF ends at 8'hE0.
- IE=8'h04; write IF=8'h00 in the same cycle as an irq_timer pulse → IF=8'hE4; the source wins.
- IF=8'h01 with IE=8'h00 → cpu_irq_n stays 1; write IE=8'h01 → cpu_irq_n=0 on the next cycle.
- Raise cpu_int_ack with pend=0 → cpu_vector=8'h00, no IF change; hold irq_timer high for 10 cycles with EDGE_DET=1 → exactly one IF set; assert reset_n=0 mid-ACK → cpu_irq_n=1, cpu_vector=8'h00 immediately.
